// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NUM_MASTERS masters share one wb_io port.
// Optional hung-slave timeout: define WB_ARB_TIMEOUT_EN to build it.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_ni,
   input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
   input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
   input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]    wbm_we_i,
   input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
   input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
   input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
   output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
   output logic [NUM_MASTERS-1:0]    wbm_ack_o,
   output logic [NUM_MASTERS-1:0]    wbm_err_o,
   output logic [NUM_MASTERS-1:0]    wbm_rty_o,
   output logic [31:0]               wbs_adr_o,
   output logic [31:0]               wbs_dat_o,
   output logic [3:0]                wbs_sel_o,
   output logic                      wbs_we_o,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic [2:0]                wbs_cti_o,
   output logic [1:0]                wbs_bte_o,
   input  logic [31:0]               wbs_dat_i,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i,
   output logic [NUM_MASTERS-1:0]    grant_o
);

   localparam int NM = NUM_MASTERS;
   localparam int LW = (NM > 1) ? $clog2(NM) : 1;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [NM-1:0] grant_q;
   logic [NM-1:0] grant_d;
   logic [LW-1:0] last_q;
   logic [LW-1:0] last_d;
   logic [LW-1:0] gidx;
   logic [LW-1:0] pick;
   logic [LW-1:0] cand;
   logic          pick_ok;
   logic          g_cyc;
   logic          g_stb;
   logic          timeout;

   // Index of the current owner, decoded from the one-hot grant
   always_comb begin
      gidx = '0;
      for (int m = 0; m < NM; m++) begin
         if (grant_q[m]) gidx = LW'(m);
      end
   end

   // Rotating priority: search last+1, last+2, ... with wrap-around
   always_comb begin
      int j;
      j       = 0;
      cand    = '0;
      pick    = last_q;
      pick_ok = 1'b0;
      for (int i = 1; i <= NM; i++) begin
         j = int'(last_q) + i;
         if (j >= NM) j = j - NM;
         cand = LW'(j);
         if (!pick_ok && wbm_cyc_i[cand]) begin
            pick    = cand;
            pick_ok = 1'b1;
         end
      end
   end

   // Owner's raw cycle/strobe; stb without cyc never reaches the bus
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      if (state_q == BUSY) begin
         g_cyc = wbm_cyc_i[gidx];
         g_stb = wbm_cyc_i[gidx] & wbm_stb_i[gidx];
      end
   end

   // Arbitration state register
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LW'(NM - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Next state: grant on any request, release when the owner drops cyc
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (pick_ok) begin
               state_d = BUSY;
               grant_d = NM'(1) << pick;
            end
         end
         BUSY: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = gidx;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Shared port mux; zero whenever nobody owns the bus
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      for (int m = 0; m < NM; m++) begin
         if (grant_q[m]) begin
            wbs_adr_o = wbm_adr_i[32*m +: 32];
            wbs_dat_o = wbm_dat_i[32*m +: 32];
            wbs_sel_o = wbm_sel_i[4*m +: 4];
            wbs_we_o  = wbm_we_i[m];
            wbs_cti_o = wbm_cti_i[3*m +: 3];
            wbs_bte_o = wbm_bte_i[2*m +: 2];
         end
      end
      wbs_cyc_o = g_cyc;
      wbs_stb_o = g_stb & ~timeout;
   end

   // Responses go to the owner only; read data is broadcast
   always_comb begin
      wbm_dat_o = {NM{wbs_dat_i}};
      wbm_ack_o = grant_q & {NM{wbs_ack_i}};
      wbm_err_o = grant_q & {NM{wbs_err_i | timeout}};
      wbm_rty_o = grant_q & {NM{wbs_rty_i}};
      grant_o   = grant_q;
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] tcnt_q;
   logic          resp;

   assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
   assign timeout = g_stb & ~resp & (tcnt_q == CW'(TIMEOUT_CYCLES));

   // Count unanswered strobe cycles; any response or release restarts
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         tcnt_q <= '0;
      end else if (!g_cyc || resp || timeout) begin
         tcnt_q <= '0;
      end else if (g_stb) begin
         tcnt_q <= tcnt_q + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
